// File: rtl/spi_controller.sv
// SPI mode-0 initiator producing 16-bit {R/W, addr[6:0], data[7:0]} frames,
// MSB first. The request fields are captured in one cycle. SCLK, nCS and COPI
// are generated from clk. CIPO is captured on read frames and returned on rdata.
//
// Request handshake: a request transfers on a rising clk edge where
// req_valid && req_ready. req_ready is high only in IDLE. While req_ready is
// low a request is not taken, and the requester holds its fields and
// req_valid stable until the transfer. The fields are don't-care once
// transferred.
module spi_controller #(
    parameter int unsigned CLK_DIV  = 4,  // clk cycles per SCLK half-period (2..255)
    parameter int unsigned CS_SETUP = 8,  // nCS fall to first SCLK rise (1..255)
    parameter int unsigned CS_HOLD  = 8,  // last SCLK fall to nCS rise (1..255)
    parameter int unsigned CS_GAP   = 8   // minimum nCS high time between frames (1..255)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [6:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       rdata_valid,
    output logic       SCLK,
    output logic       nCS,
    output logic       COPI,
    input  logic       CIPO,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_HOLD  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // Terminal values of the shared phase counter; each phase lasts N cycles.
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(CS_GAP - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;       // cycles spent in the current phase
    logic [3:0]  bit_cnt_q;   // index of the SCLK high phase in progress
    logic [14:0] frame_q;     // bits still to send; the next bit is in [14]
    logic        write_q;     // R/W bit of the frame in flight
    logic [7:0]  rx_shift_q;  // last 8 sampled CIPO bits, newest in bit 0
    logic        cipo_meta_q;
    logic        cipo_sync_q;
    logic        sclk_q;
    logic        ncs_q;
    logic        copi_q;
    logic        ready_q;
    logic        busy_q;
    logic        done_q;
    logic        rvalid_q;
    logic [7:0]  rdata_q;

    // Bring CIPO into the clk domain through two flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo_meta_q <= 1'b0;
            cipo_sync_q <= 1'b0;
        end else begin
            cipo_meta_q <= CIPO;
            cipo_sync_q <= cipo_meta_q;
        end
    end

    // Frame sequencer. All serial and status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            bit_cnt_q  <= 4'd0;
            frame_q    <= 15'd0;
            write_q    <= 1'b0;
            rx_shift_q <= 8'd0;
            sclk_q     <= 1'b0;
            ncs_q      <= 1'b1;
            copi_q     <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 8'd0;
        end else begin
            // Completion strobes are single-cycle unless set below.
            done_q   <= 1'b0;
            rvalid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid && ready_q) begin
                        // The R/W bit goes straight onto COPI. Address and
                        // data wait in frame_q.
                        frame_q <= {req_addr, req_wdata};
                        write_q <= req_write;
                        copi_q  <= req_write;
                        ncs_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        sclk_q    <= 1'b1;
                        cnt_q     <= 8'd0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == DIV_LAST) begin
                        // Sample as late as possible in the high phase so the
                        // synchronised CIPO has settled.
                        rx_shift_q <= {rx_shift_q[6:0], cipo_sync_q};
                        sclk_q     <= 1'b0;
                        cnt_q      <= 8'd0;
                        if (bit_cnt_q == 4'd15) begin
                            state_q <= S_HOLD;
                        end else begin
                            // The next bit changes together with the falling
                            // edge of SCLK, well away from the next rising edge.
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            copi_q    <= frame_q[14];
                            frame_q   <= {frame_q[13:0], 1'b0};
                            state_q   <= S_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_LOW: begin
                    if (cnt_q == DIV_LAST) begin
                        sclk_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                        state_q <= S_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        ncs_q  <= 1'b1;
                        copi_q <= 1'b0;
                        done_q <= 1'b1;
                        // Write frames leave rdata untouched.
                        if (!write_q) begin
                            rdata_q  <= rx_shift_q;
                            rvalid_q <= 1'b1;
                        end
                        cnt_q   <= 8'd0;
                        state_q <= S_GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        cnt_q   <= 8'd0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    // Unreachable encodings fall back to a quiet idle bus.
                    sclk_q  <= 1'b0;
                    ncs_q   <= 1'b1;
                    copi_q  <= 1'b0;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= 8'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rvalid_q;
    assign SCLK        = sclk_q;
    assign nCS         = ncs_q;
    assign COPI        = copi_q;
    assign dbg_state_o = state_q;

endmodule
